tr_baser_link_ctrl: RTL and testbench
=====================================

// Module: tr_baser_link_ctrl
// PURPOSE
//  Multi-channel 10GBASE-R reset/link sequencer replacing the single-channel vendor reset IP.
//  Sits between the shared fPLL plus NUM_CH transceiver channels and the MAC side.
//  One shared TX/PLL FSM; one RX FSM per channel.
//  Adds block-lock supervision, timeout-driven RX retraining and per-channel relock counters.
// PARAMETERS
//  NUM_CH       4      number of transceiver channels
//  T_PLL_PD     1000   cycles pll_powerdown is held after reset
//  T_ANA        100    cycles cal_busy must stay low before analog reset release
//  T_DIG        100    cycles between analog and digital reset release
//  T_CDR        1000   cycles rx_is_lockedtodata must stay high before digital release
//  BLK_TIMEOUT  65535  max cycles in R_BLK waiting for block lock
//  BLK_LOSS     16     consecutive cycles of block-lock loss that trigger retrain
//  CNT_W        8      relock counter width (per channel)
// PORTS
//  clk_glbl            in   1            free-running management clock
//  rst_glbl            in   1            synchronous, active-high reset
//  pll_locked          in   1            fPLL locked (async)
//  pll_cal_busy        in   1            fPLL calibration busy (async)
//  tx_cal_busy         in   NUM_CH       per-channel TX calibration busy (async)
//  rx_cal_busy         in   NUM_CH       per-channel RX calibration busy (async)
//  rx_is_lockedtodata  in   NUM_CH       CDR locked to data (async)
//  rx_blk_lock         in   NUM_CH       PCS block lock (async)
//  pll_powerdown       out  1            fPLL powerdown
//  tx_analogreset      out  NUM_CH       TX PMA reset (all bits driven identically)
//  tx_digitalreset     out  NUM_CH       TX PCS reset (all bits driven identically)
//  tx_ready            out  NUM_CH       TX path usable
//  rx_analogreset      out  NUM_CH       RX PMA reset
//  rx_digitalreset     out  NUM_CH       RX PCS reset
//  rx_ready            out  NUM_CH       RX digital reset released
//  link_up             out  NUM_CH       block lock qualified, channel up
//  relock_cnt          out  NUM_CH*CNT_W per-channel retrain count; ch i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  - Every async input passes a 2-flop synchronizer (2 cycles latency); all logic below uses the _s copies.
//  - Reset values: pll_powerdown=1, all analog/digital resets=1, tx_ready=0, rx_ready=0,
//    link_up=0, relock_cnt=0, TX FSM=T_PD, RX FSMs=R_ANA.
//  - rst_glbl mid-operation forces reset values on the next edge. No other path is exempt.
//  - "Held N cycles": a dwell counter restarts whenever the condition drops. The exit edge is the
//    Nth consecutive cycle the condition is true.
//  - TX FSM:
//    - T_PD: pll_powerdown=1. Go to T_ANA after T_PLL_PD cycles.
//    - T_ANA: pll_powerdown=0; tx analog and digital resets=1. Go to T_DIG once
//      (pll_locked & ~pll_cal_busy & ~|tx_cal_busy) has held T_ANA cycles.
//    - T_DIG: analog=0, digital=1. Go to T_RDY after T_DIG cycles.
//    - T_RDY: digital=0, tx_ready=all 1.
//    - In T_DIG or T_RDY, pll_locked_s=0 returns to T_ANA next cycle: resets reasserted, tx_ready=0 on that edge.
//  - RX FSM (per channel, independent of TX and of the other channels):
//    - R_ANA: analog=1, digital=1. Go to R_CDR once ~rx_cal_busy has held T_ANA cycles.
//    - R_CDR: analog=0. Go to R_DIG once lockedtodata has held T_CDR cycles.
//    - R_DIG: digital=1. Go to R_BLK after T_DIG cycles.
//    - R_BLK: digital=0, rx_ready=1.
//      - blk_lock_s=1 -> R_UP.
//      - BLK_TIMEOUT cycles without lock -> R_ANA and relock++.
//    - R_UP: rx_ready=1, link_up=1.
//      - lockedtodata_s=0 -> R_ANA immediately and relock++.
//      - blk_lock_s=0 held BLK_LOSS cycles -> R_ANA and relock++.
//      - Shorter lock glitches are ignored and link_up stays 1.
//    - R_BLK or R_UP with lockedtodata_s=0 -> R_ANA and relock++. This takes priority over timeout/loss in the same cycle.
//  - relock_cnt saturates at 2^CNT_W-1; it never wraps. Cleared only by rst_glbl.
//  - All outputs are registered (state-decoded flops). Output changes on the edge the state changes.
//  - Dwell counter width: $clog2(max(T_*,BLK_TIMEOUT)+1).
// STRUCTURE
//  - tr_baser_pkg: tx_state_t (T_PD,T_ANA,T_DIG,T_RDY) and rx_state_t (R_ANA,R_CDR,R_DIG,R_BLK,R_UP) enums.
//    Also holds the shared sync2 macro/function constant SYNC_STAGES=2.
//  - Sub-module tr_baser_rx_seq: one RX FSM, dwell counter and relock counter. Instantiated NUM_CH times in a generate loop.
//  - Top holds the synchronizers and the TX FSM.
// TESTING  (NUM_CH=2, T_PLL_PD=8, T_ANA=4, T_DIG=4, T_CDR=8, BLK_TIMEOUT=32, BLK_LOSS=4)
//  1 Power-up: release rst, hold pll_locked=1, no cal_busy.
//    -> pll_powerdown falls after 8 cycles, tx_analogreset falls after a further 4+2 sync cycles.
//    -> tx_ready rises 4 cycles later.
//  2 RX bring-up ch0: lockedtodata=1 then blk_lock=1.
//    -> rx_ready[0] rises after the T_CDR+T_DIG dwell; link_up[0] rises 3 cycles after blk_lock (sync + FSM).
//  3 Block-lock glitch: in R_UP, drop blk_lock 3 cycles -> link_up stays 1, relock_cnt=0.
//    Drop it 6 cycles -> link_up=0, rx_analogreset=1, relock_cnt[0]=1. Ch1 is unaffected.
//  4 No block lock: hold blk_lock=0 -> R_BLK times out every 32 cycles plus the bring-up dwell.
//    -> relock_cnt increments each time; with CNT_W=2 it saturates at 3.
//  5 PLL loss: in T_RDY, drop pll_locked 1 cycle -> tx_ready=0 and tx_analogreset=1 within 3 cycles.
//    -> Full T_ANA+T_DIG re-sequence before tx_ready returns.
//  6 Mid-operation reset: assert rst_glbl 1 cycle with both links up
//    -> all outputs reach reset values next edge, relock_cnt=0.

Source files
------------

// File: rtl/tr_baser_pkg.sv
// Shared types and constants for the 10GBASE-R multi-channel reset/link sequencer.
package tr_baser_pkg;

    // Depth of every async-input synchronizer.
    localparam int unsigned SYNC_STAGES = 2;

    // Shared TX/PLL sequencer states.
    typedef enum logic [1:0] {
        TX_PD,
        TX_ANA,
        TX_DIG,
        TX_RDY
    } tx_state_t;

    // Per-channel RX sequencer states.
    typedef enum logic [2:0] {
        R_ANA,
        R_CDR,
        R_DIG,
        R_BLK,
        R_UP
    } rx_state_t;

    // Larger of two values, used to size dwell counters at elaboration.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tr_baser_rx_seq.sv
// One RX channel sequencer: PMA/PCS reset release, block-lock supervision, retrain counting.
module tr_baser_rx_seq
    import tr_baser_pkg::*;
#(
    parameter int unsigned T_ANA       = 100,
    parameter int unsigned T_DIG       = 100,
    parameter int unsigned T_CDR       = 1000,
    parameter int unsigned BLK_TIMEOUT = 65535,
    parameter int unsigned BLK_LOSS    = 16,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DW          = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cal_busy_s,
    input  logic             locked_s,
    input  logic             blk_lock_s,
    output logic             analogreset,
    output logic             digitalreset,
    output logic             ready,
    output logic             link_up,
    output logic [CNT_W-1:0] relock_cnt
);

    rx_state_t        state, state_d;
    logic [DW-1:0]    cnt, cnt_d;
    logic             relock_inc;
    logic             ana_d, dig_d, rdy_d, up_d;
    logic [CNT_W-1:0] relock_cnt_d;

    // State and dwell counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= R_ANA;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next state; dwell counter restarts on any state change or dropped condition.
    always_comb begin
        state_d    = state;
        cnt_d      = '0;
        relock_inc = 1'b0;
        case (state)
            R_ANA: begin
                if (!cal_busy_s) begin
                    if (cnt == DW'(T_ANA - 1)) state_d = R_CDR;
                    else                       cnt_d   = cnt + DW'(1);
                end
            end
            R_CDR: begin
                if (locked_s) begin
                    if (cnt == DW'(T_CDR - 1)) state_d = R_DIG;
                    else                       cnt_d   = cnt + DW'(1);
                end
            end
            R_DIG: begin
                if (cnt == DW'(T_DIG - 1)) state_d = R_BLK;
                else                       cnt_d   = cnt + DW'(1);
            end
            R_BLK: begin
                // CDR loss wins over block-lock timeout
                if (!locked_s) begin
                    state_d    = R_ANA;
                    relock_inc = 1'b1;
                end else if (blk_lock_s) begin
                    state_d = R_UP;
                end else if (cnt == DW'(BLK_TIMEOUT - 1)) begin
                    state_d    = R_ANA;
                    relock_inc = 1'b1;
                end else begin
                    cnt_d = cnt + DW'(1);
                end
            end
            R_UP: begin
                // CDR loss wins over sustained block-lock loss
                if (!locked_s) begin
                    state_d    = R_ANA;
                    relock_inc = 1'b1;
                end else if (!blk_lock_s) begin
                    if (cnt == DW'(BLK_LOSS - 1)) begin
                        state_d    = R_ANA;
                        relock_inc = 1'b1;
                    end else begin
                        cnt_d = cnt + DW'(1);
                    end
                end
            end
            default: state_d = R_ANA;
        endcase
    end

    // Output decode from the next state so outputs change on the same edge as the state.
    always_comb begin
        ana_d        = 1'b0;
        dig_d        = 1'b0;
        rdy_d        = 1'b0;
        up_d         = 1'b0;
        relock_cnt_d = relock_cnt;
        case (state_d)
            R_ANA:   begin ana_d = 1'b1; dig_d = 1'b1; end
            R_CDR:   dig_d = 1'b1;
            R_DIG:   dig_d = 1'b1;
            R_BLK:   rdy_d = 1'b1;
            R_UP:    begin rdy_d = 1'b1; up_d = 1'b1; end
            default: begin ana_d = 1'b1; dig_d = 1'b1; end
        endcase
        if (relock_inc && (relock_cnt != {CNT_W{1'b1}}))
            relock_cnt_d = relock_cnt + CNT_W'(1);
    end

    // Registered outputs and saturating relock counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            analogreset  <= 1'b1;
            digitalreset <= 1'b1;
            ready        <= 1'b0;
            link_up      <= 1'b0;
            relock_cnt   <= '0;
        end else begin
            analogreset  <= ana_d;
            digitalreset <= dig_d;
            ready        <= rdy_d;
            link_up      <= up_d;
            relock_cnt   <= relock_cnt_d;
        end
    end

endmodule

// File: rtl/tr_baser_link_ctrl.sv
// Multi-channel 10GBASE-R reset/link sequencer: input synchronizers, shared TX/PLL FSM, per-channel RX FSMs.
module tr_baser_link_ctrl
    import tr_baser_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned T_PLL_PD    = 1000,
    parameter int unsigned T_ANA       = 100,
    parameter int unsigned T_DIG       = 100,
    parameter int unsigned T_CDR       = 1000,
    parameter int unsigned BLK_TIMEOUT = 65535,
    parameter int unsigned BLK_LOSS    = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic                    clk_glbl,
    input  logic                    rst_glbl,
    input  logic                    pll_locked,
    input  logic                    pll_cal_busy,
    input  logic [NUM_CH-1:0]       tx_cal_busy,
    input  logic [NUM_CH-1:0]       rx_cal_busy,
    input  logic [NUM_CH-1:0]       rx_is_lockedtodata,
    input  logic [NUM_CH-1:0]       rx_blk_lock,
    output logic                    pll_powerdown,
    output logic [NUM_CH-1:0]       tx_analogreset,
    output logic [NUM_CH-1:0]       tx_digitalreset,
    output logic [NUM_CH-1:0]       tx_ready,
    output logic [NUM_CH-1:0]       rx_analogreset,
    output logic [NUM_CH-1:0]       rx_digitalreset,
    output logic [NUM_CH-1:0]       rx_ready,
    output logic [NUM_CH-1:0]       link_up,
    output logic [NUM_CH*CNT_W-1:0] relock_cnt
);

    localparam int unsigned DWELL_MAX = max_u(max_u(max_u(T_PLL_PD, T_ANA), max_u(T_DIG, T_CDR)),
                                              max_u(BLK_TIMEOUT, BLK_LOSS));
    localparam int unsigned DW        = $clog2(DWELL_MAX + 1);
    localparam int unsigned AW        = 2 + 4 * NUM_CH;

    logic [AW-1:0]     async_vec;
    logic [AW-1:0]     sync_q [SYNC_STAGES];
    logic              pll_locked_s, pll_cal_busy_s;
    logic [NUM_CH-1:0] tx_cal_busy_s, rx_cal_busy_s, rx_locked_s, rx_blk_lock_s;

    assign async_vec = {pll_locked, pll_cal_busy, tx_cal_busy, rx_cal_busy, rx_is_lockedtodata, rx_blk_lock};
    assign {pll_locked_s, pll_cal_busy_s, tx_cal_busy_s, rx_cal_busy_s, rx_locked_s, rx_blk_lock_s} =
           sync_q[SYNC_STAGES-1];

    // Two-flop synchronizers for every async status input.
    always_ff @(posedge clk_glbl) begin
        if (rst_glbl) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= async_vec;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    tx_state_t     tx_state, tx_state_d;
    logic [DW-1:0] tx_cnt, tx_cnt_d;
    logic          tx_ana_ok;
    logic          pd_d, tx_ana_d, tx_dig_d, tx_rdy_d;

    assign tx_ana_ok = pll_locked_s & ~pll_cal_busy_s & ~|tx_cal_busy_s;

    // TX state and dwell counter register.
    always_ff @(posedge clk_glbl) begin
        if (rst_glbl) begin
            tx_state <= TX_PD;
            tx_cnt   <= '0;
        end else begin
            tx_state <= tx_state_d;
            tx_cnt   <= tx_cnt_d;
        end
    end

    // TX next state; PLL loss after analog release restarts the analog phase.
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = '0;
        case (tx_state)
            TX_PD: begin
                if (tx_cnt == DW'(T_PLL_PD - 1)) tx_state_d = TX_ANA;
                else                             tx_cnt_d   = tx_cnt + DW'(1);
            end
            TX_ANA: begin
                if (tx_ana_ok) begin
                    if (tx_cnt == DW'(T_ANA - 1)) tx_state_d = TX_DIG;
                    else                          tx_cnt_d   = tx_cnt + DW'(1);
                end
            end
            TX_DIG: begin
                if (!pll_locked_s)                 tx_state_d = TX_ANA;
                else if (tx_cnt == DW'(T_DIG - 1)) tx_state_d = TX_RDY;
                else                               tx_cnt_d   = tx_cnt + DW'(1);
            end
            TX_RDY: begin
                if (!pll_locked_s) tx_state_d = TX_ANA;
            end
            default: tx_state_d = TX_PD;
        endcase
    end

    // TX output decode from the next state.
    always_comb begin
        pd_d     = 1'b0;
        tx_ana_d = 1'b0;
        tx_dig_d = 1'b1;
        tx_rdy_d = 1'b0;
        case (tx_state_d)
            TX_PD:   begin pd_d = 1'b1; tx_ana_d = 1'b1; end
            TX_ANA:  tx_ana_d = 1'b1;
            TX_DIG:  tx_dig_d = 1'b1;
            TX_RDY:  begin tx_dig_d = 1'b0; tx_rdy_d = 1'b1; end
            default: begin pd_d = 1'b1; tx_ana_d = 1'b1; end
        endcase
    end

    // Registered TX/PLL outputs; one status drives every channel.
    always_ff @(posedge clk_glbl) begin
        if (rst_glbl) begin
            pll_powerdown   <= 1'b1;
            tx_analogreset  <= '1;
            tx_digitalreset <= '1;
            tx_ready        <= '0;
        end else begin
            pll_powerdown   <= pd_d;
            tx_analogreset  <= {NUM_CH{tx_ana_d}};
            tx_digitalreset <= {NUM_CH{tx_dig_d}};
            tx_ready        <= {NUM_CH{tx_rdy_d}};
        end
    end

    // Independent RX sequencer per channel.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_rx
        tr_baser_rx_seq #(
            .T_ANA       (T_ANA),
            .T_DIG       (T_DIG),
            .T_CDR       (T_CDR),
            .BLK_TIMEOUT (BLK_TIMEOUT),
            .BLK_LOSS    (BLK_LOSS),
            .CNT_W       (CNT_W),
            .DW          (DW)
        ) u_rx_seq (
            .clk          (clk_glbl),
            .rst          (rst_glbl),
            .cal_busy_s   (rx_cal_busy_s[g]),
            .locked_s     (rx_locked_s[g]),
            .blk_lock_s   (rx_blk_lock_s[g]),
            .analogreset  (rx_analogreset[g]),
            .digitalreset (rx_digitalreset[g]),
            .ready        (rx_ready[g]),
            .link_up      (link_up[g]),
            .relock_cnt   (relock_cnt[g*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_tr_baser_link_ctrl.sv
// Directed timeline bench for tr_baser_link_ctrl (2 channels, short timers, 2-bit relock counters).
module tb_tr_baser_link_ctrl;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CNT_W  = 2;

    logic                    clk = 1'b0;
    logic                    rst_glbl = 1'b1;
    logic                    pll_locked = 1'b0;
    logic                    pll_cal_busy = 1'b0;
    logic [NUM_CH-1:0]       tx_cal_busy = '0;
    logic [NUM_CH-1:0]       rx_cal_busy = '0;
    logic [NUM_CH-1:0]       rx_is_lockedtodata = '0;
    logic [NUM_CH-1:0]       rx_blk_lock = '0;
    logic                    pll_powerdown;
    logic [NUM_CH-1:0]       tx_analogreset, tx_digitalreset, tx_ready;
    logic [NUM_CH-1:0]       rx_analogreset, rx_digitalreset, rx_ready, link_up;
    logic [NUM_CH*CNT_W-1:0] relock_cnt;

    always #5 clk = ~clk;

    tr_baser_link_ctrl #(
        .NUM_CH      (NUM_CH),
        .T_PLL_PD    (8),
        .T_ANA       (4),
        .T_DIG       (4),
        .T_CDR       (8),
        .BLK_TIMEOUT (32),
        .BLK_LOSS    (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_glbl           (clk),
        .rst_glbl           (rst_glbl),
        .pll_locked         (pll_locked),
        .pll_cal_busy       (pll_cal_busy),
        .tx_cal_busy        (tx_cal_busy),
        .rx_cal_busy        (rx_cal_busy),
        .rx_is_lockedtodata (rx_is_lockedtodata),
        .rx_blk_lock        (rx_blk_lock),
        .pll_powerdown      (pll_powerdown),
        .tx_analogreset     (tx_analogreset),
        .tx_digitalreset    (tx_digitalreset),
        .tx_ready           (tx_ready),
        .rx_analogreset     (rx_analogreset),
        .rx_digitalreset    (rx_digitalreset),
        .rx_ready           (rx_ready),
        .link_up            (link_up),
        .relock_cnt         (relock_cnt)
    );

    // One timeline step: drive inputs, advance n clocks, compare every output.
    // exp = {pd, txa[1:0], txd[1:0], txr[1:0], rxa[1:0], rxd[1:0], rxr[1:0], lu[1:0], rc1[1:0], rc0[1:0]}
    typedef struct packed {
        logic        rst;
        logic        pll;
        logic [1:0]  lk;
        logic [1:0]  blk;
        logic [7:0]  n;
        logic [18:0] exp;
    } vec_t;

    vec_t  tv[$];
    string tn[$];
    int    n_cmp = 0;
    int    n_err = 0;

    function automatic void add(input string nm, input logic rst, input logic pll,
                                input logic [1:0] lk, input logic [1:0] blk, input int n,
                                input logic pd, input logic [1:0] txa, input logic [1:0] txd,
                                input logic [1:0] txr, input logic [1:0] rxa, input logic [1:0] rxd,
                                input logic [1:0] rxr, input logic [1:0] lu, input logic [3:0] rc);
        vec_t v;
        v.rst = rst; v.pll = pll; v.lk = lk; v.blk = blk; v.n = 8'(n);
        v.exp = {pd, txa, txd, txr, rxa, rxd, rxr, lu, rc};
        tv.push_back(v);
        tn.push_back(nm);
    endfunction

    function automatic logic [18:0] obs();
        return {pll_powerdown, tx_analogreset, tx_digitalreset, tx_ready,
                rx_analogreset, rx_digitalreset, rx_ready, link_up, relock_cnt};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string nm, input logic [18:0] got, input logic [18:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", nm, got, exp);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    initial begin
        int k;
        //  name              rst pll lk     blk    n   pd    txa    txd    txr    rxa    rxd    rxr    lu     rc
        add("reset",          1, 0, 2'b00, 2'b00,  2, 1'b1, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 4'h0);
        add("pd_hold",        0, 0, 2'b00, 2'b00,  7, 1'b1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 4'h0);
        add("pd_fall",        0, 0, 2'b00, 2'b00,  1, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 4'h0);
        add("tx_ana_hold",    0, 1, 2'b00, 2'b00,  5, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 4'h0);
        add("tx_ana_rel",     0, 1, 2'b00, 2'b00,  1, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 4'h0);
        add("tx_dig_hold",    0, 1, 2'b00, 2'b00,  3, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 4'h0);
        add("tx_ready",       0, 1, 2'b00, 2'b00,  1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 4'h0);
        add("rx_dig_hold",    0, 1, 2'b11, 2'b00, 13, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 4'h0);
        add("rx_ready",       0, 1, 2'b11, 2'b00,  1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 4'h0);
        add("blk_sync",       0, 1, 2'b11, 2'b11,  2, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 4'h0);
        add("link_up",        0, 1, 2'b11, 2'b11,  1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 4'h0);
        add("glitch3",        0, 1, 2'b11, 2'b10,  3, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 4'h0);
        add("glitch3_after",  0, 1, 2'b11, 2'b11,  6, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 4'h0);
        add("loss_hold",      0, 1, 2'b11, 2'b10,  5, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 4'h0);
        add("loss_retrain",   0, 1, 2'b11, 2'b10,  1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10, 4'h1);
        add("ch0_reblk",      0, 1, 2'b11, 2'b11, 16, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b10, 4'h1);
        add("ch0_relink",     0, 1, 2'b11, 2'b11,  1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 4'h1);
        add("pll_drop",       0, 0, 2'b11, 2'b11,  1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 4'h1);
        add("pll_back",       0, 1, 2'b11, 2'b11,  1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 4'h1);
        add("tx_lost",        0, 1, 2'b11, 2'b11,  1, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 4'h1);
        add("tx_reana",       0, 1, 2'b11, 2'b11,  3, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 4'h1);
        add("tx_redig",       0, 1, 2'b11, 2'b11,  1, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 4'h1);
        add("tx_reready",     0, 1, 2'b11, 2'b11,  4, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 4'h1);
        add("ch1_loss_hold",  0, 1, 2'b11, 2'b01,  5, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 4'h1);
        add("ch1_loss",       0, 1, 2'b11, 2'b01,  1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 4'h5);
        add("ch1_blk",        0, 1, 2'b11, 2'b01, 16, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 4'h5);
        add("ch1_blk_hold",   0, 1, 2'b11, 2'b01, 31, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b01, 4'h5);
        add("ch1_timeout1",   0, 1, 2'b11, 2'b01,  1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 4'h9);
        add("ch1_timeout2",   0, 1, 2'b11, 2'b01, 48, 1'b0, 2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 4'hd);
        add("ch1_saturated",  0, 1, 2'b11, 2'b01, 48, 1'b0, 2'b00, 2'b00, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01, 4'hd);
        add("ch1_relink",     0, 1, 2'b11, 2'b11, 17, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 4'hd);
        add("cdr_drop_sync",  0, 1, 2'b10, 2'b11,  2, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, 2'b11, 4'hd);
        add("cdr_drop",       0, 1, 2'b11, 2'b11,  1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b01, 2'b01, 2'b10, 2'b10, 4'he);
        add("mid_reset",      1, 1, 2'b11, 2'b11,  1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 4'h0);
        add("post_reset",     0, 1, 2'b11, 2'b11,  1, 1'b1, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, 4'h0);

        #1;
        for (int i = 0; i < tv.size(); i++) begin
            rst_glbl           = tv[i].rst;
            pll_locked         = tv[i].pll;
            rx_is_lockedtodata = tv[i].lk;
            rx_blk_lock        = tv[i].blk;
            tick(int'(tv[i].n));
            check_vec(tn[i], obs(), tv[i].exp);
        end

        // PLL already locked after reset: powerdown held exactly T_PLL_PD cycles.
        k = 0;
        while (pll_powerdown && k < 40) begin
            tick(1);
            k++;
        end
        check_int("pd_release_cycles", k, 7);

        // A one-cycle cal_busy pulse early in the T_ANA dwell restarts it (2 ok + 1 blocked + 4 ok).
        pll_cal_busy = 1'b1;
        tick(1);
        pll_cal_busy = 1'b0;
        k = 1;
        while (tx_analogreset != '0 && k < 50) begin
            tick(1);
            k++;
        end
        check_int("cal_glitch_restart", k, 7);

        tick(3);
        check_int("tx_ready_before_dig", int'(tx_ready), 0);
        tick(1);
        check_int("tx_ready_after_dig", int'(tx_ready), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
